// File: rtl/vend_pkg.sv
// Shared types and constants for the vend_accept coin acceptor.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    NICKEL  = 2'd1,
    DIME    = 2'd2,
    QUARTER = 2'd3
  } coin_e;

  localparam int unsigned NICKEL_VAL  = 5;
  localparam int unsigned DIME_VAL    = 10;
  localparam int unsigned QUARTER_VAL = 25;

endpackage

// File: rtl/vend_accept_if.sv
// Customer/dispenser-facing signal bundle of vend_accept; slave = acceptor, master = environment.
interface vend_accept_if #(
  parameter int PRICE = 20
);
  import vend_pkg::*;

  localparam int DEP_W = $clog2(PRICE + 21);

  logic             nickel_i;
  logic             dime_i;
  logic             quarter_i;
  logic             cancel_i;
  logic             vend_ack_i;
  logic             vend_o;
  logic             change_valid_o;
  logic [1:0]       change_coin_o;
  logic             coin_reject_o;
  logic             busy_o;
  logic [DEP_W-1:0] deposit_o;
  state_e           dbg_state;

  // vend_o is a request held high until the cycle vend_ack_i is sampled high;
  // that edge completes the transfer and vend_o is low in the following cycle.
  modport slave (
    input  nickel_i, dime_i, quarter_i, cancel_i, vend_ack_i,
    output vend_o, change_valid_o, change_coin_o, coin_reject_o, busy_o,
           deposit_o, dbg_state
  );

  modport master (
    output nickel_i, dime_i, quarter_i, cancel_i, vend_ack_i,
    input  vend_o, change_valid_o, change_coin_o, coin_reject_o, busy_o,
           deposit_o, dbg_state
  );

endinterface

// File: rtl/vend_change_sel.sv
// Picks the largest coin that fits the outstanding remainder (combinational).
module vend_change_sel
  import vend_pkg::*;
#(
  parameter int DEP_W = 6
) (
  input  logic [DEP_W-1:0] rem,
  output coin_e            coin,
  output logic [DEP_W-1:0] value
);

  always_comb begin
    coin  = NONE;
    value = '0;
    if (rem >= DEP_W'(QUARTER_VAL)) begin
      coin  = QUARTER;
      value = DEP_W'(QUARTER_VAL);
    end else if (rem >= DEP_W'(DIME_VAL)) begin
      coin  = DIME;
      value = DEP_W'(DIME_VAL);
    end else if (rem != '0) begin
      coin  = NICKEL;
      value = DEP_W'(NICKEL_VAL);
    end
  end

endmodule

// File: rtl/vend_accept.sv
// Coin acceptor FSM: collects coins, requests a vend, returns change.
// Optional refund-on-cancel is enabled by defining VEND_ACCEPT_REFUND_EN.
module vend_accept
  import vend_pkg::*;
#(
  parameter int PRICE = 20
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  vend_accept_if.slave  bus
);

  localparam int DEP_W = $clog2(PRICE + 21);
  localparam logic [DEP_W-1:0] PRICE_D = DEP_W'(PRICE);

  state_e           state_q;
  logic [DEP_W-1:0] deposit_q;
  logic             vend_q;
  logic             change_valid_q;
  coin_e            change_coin_q;
  logic             coin_reject_q;
  logic             busy_q;

  logic             any_coin;
  logic             multi_coin;
  logic [DEP_W-1:0] in_val;
  logic [DEP_W-1:0] sum;
  logic [DEP_W-1:0] vend_rem;
  logic             cancel_hit;
  coin_e            sel_coin;
  logic [DEP_W-1:0] sel_val;

  vend_change_sel #(.DEP_W(DEP_W)) u_change_sel (
    .rem   (deposit_q),
    .coin  (sel_coin),
    .value (sel_val)
  );

  // Nickel has priority, then dime, then quarter; the rest are refused.
  always_comb begin
    in_val = '0;
    if (bus.nickel_i)       in_val = DEP_W'(NICKEL_VAL);
    else if (bus.dime_i)    in_val = DEP_W'(DIME_VAL);
    else if (bus.quarter_i) in_val = DEP_W'(QUARTER_VAL);
  end

  assign any_coin   = bus.nickel_i | bus.dime_i | bus.quarter_i;
  assign multi_coin = (bus.nickel_i & bus.dime_i) | (bus.nickel_i & bus.quarter_i) |
                      (bus.dime_i & bus.quarter_i);
  assign sum        = deposit_q + in_val;
  assign vend_rem   = deposit_q - PRICE_D;

`ifdef VEND_ACCEPT_REFUND_EN
  assign cancel_hit = bus.cancel_i && (state_q == COLLECT);
`else
  logic unused_cancel;
  assign unused_cancel = bus.cancel_i;
  assign cancel_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      deposit_q      <= '0;
      vend_q         <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= NONE;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      change_valid_q <= 1'b0;
      change_coin_q  <= NONE;
      coin_reject_q  <= 1'b0;
      case (state_q)
        IDLE, COLLECT: begin
          if (cancel_hit) begin
            state_q       <= CHANGE;
            busy_q        <= 1'b1;
            coin_reject_q <= any_coin;
          end else if (any_coin) begin
            deposit_q     <= sum;
            coin_reject_q <= multi_coin;
            // COLLECT holds less than PRICE, so sum never exceeds PRICE+20.
            if (sum >= PRICE_D) begin
              state_q <= VEND;
              vend_q  <= 1'b1;
              busy_q  <= 1'b1;
            end else begin
              state_q <= COLLECT;
            end
          end
        end
        VEND: begin
          coin_reject_q <= any_coin;
          if (bus.vend_ack_i) begin
            deposit_q <= vend_rem;
            vend_q    <= 1'b0;
            if (vend_rem == '0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= CHANGE;
            end
          end
        end
        CHANGE: begin
          coin_reject_q  <= any_coin;
          deposit_q      <= deposit_q - sel_val;
          change_valid_q <= 1'b1;
          change_coin_q  <= sel_coin;
          if (deposit_q == sel_val) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.vend_o         = vend_q;
  assign bus.change_valid_o = change_valid_q;
  assign bus.change_coin_o  = change_coin_q;
  assign bus.coin_reject_o  = coin_reject_q;
  assign bus.busy_o         = busy_q;
  assign bus.deposit_o      = deposit_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_vend_accept.sv
// Directed bench for vend_accept (PRICE=20) with a change-coin scoreboard.
module tb_vend_accept;
  import vend_pkg::*;

  localparam int PRICE = 20;

  logic clk;
  logic rst_n;

  vend_accept_if #(.PRICE(PRICE)) bus ();

  vend_accept #(.PRICE(PRICE)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  int n_checks   = 0;
  int n_errors   = 0;
  int obs_reject = 0;
  int exp_reject = 0;
  logic [1:0] exp_q[$];

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: inputs are applied at a falling edge and held through one rising edge
  task automatic step(input logic n, input logic d, input logic q, input logic c,
                      input logic a);
    bus.nickel_i   = n;
    bus.dime_i     = d;
    bus.quarter_i  = q;
    bus.cancel_i   = c;
    bus.vend_ack_i = a;
    @(negedge clk);
    bus.nickel_i   = 1'b0;
    bus.dime_i     = 1'b0;
    bus.quarter_i  = 1'b0;
    bus.cancel_i   = 1'b0;
    bus.vend_ack_i = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  // scoreboard: change coins are compared in order against exp_q
  always @(negedge clk) begin
    if (rst_n && bus.coin_reject_o) obs_reject++;
    if (bus.change_valid_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        assert (exp_q.size() != 0) else begin
          n_errors++;
          $error("FAIL change_unexpected: observed coin %0d expected no change", bus.change_coin_o);
        end
      end else begin
        check("change_coin", 32'(bus.change_coin_o), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst_n          = 1'b0;
    bus.nickel_i   = 1'b0;
    bus.dime_i     = 1'b0;
    bus.quarter_i  = 1'b0;
    bus.cancel_i   = 1'b0;
    bus.vend_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_deposit", 32'(bus.deposit_o), 0);
    check("rst_vend", 32'(bus.vend_o), 0);
    check("rst_busy", 32'(bus.busy_o), 0);
    check("rst_state", 32'(bus.dbg_state), 32'(IDLE));
    rst_n = 1'b1;
    idle_cycles($urandom_range(1, 3));

    // exact price with two dimes, no change
    step(0, 1, 0, 0, 0);
    check("d1_deposit", 32'(bus.deposit_o), 10);
    check("d1_vend", 32'(bus.vend_o), 0);
    step(0, 1, 0, 0, 0);
    check("d2_deposit", 32'(bus.deposit_o), 20);
    check("d2_vend", 32'(bus.vend_o), 1);
    check("d2_busy", 32'(bus.busy_o), 1);
    step(0, 0, 0, 0, 1);
    check("ack_vend", 32'(bus.vend_o), 0);
    check("ack_deposit", 32'(bus.deposit_o), 0);
    check("ack_state", 32'(bus.dbg_state), 32'(IDLE));
    idle_cycles($urandom_range(1, 3));

    // simultaneous nickel and dime: nickel kept, dime refused
    step(1, 1, 0, 0, 0);
    exp_reject++;
    check("nd_deposit", 32'(bus.deposit_o), 5);
    check("nd_reject", 32'(bus.coin_reject_o), 1);
    step(0, 1, 0, 0, 0);
    check("nd_reject_clr", 32'(bus.coin_reject_o), 0);
    check("c15_deposit", 32'(bus.deposit_o), 15);

    // overpay to 40: two dime change coins after ack
    step(0, 0, 1, 0, 0);
    check("q40_deposit", 32'(bus.deposit_o), 40);
    check("q40_vend", 32'(bus.vend_o), 1);
    step(0, 0, 1, 0, 0);
    exp_reject++;
    check("vq_reject", 32'(bus.coin_reject_o), 1);
    check("vq_deposit", 32'(bus.deposit_o), 40);
    exp_q.push_back(2'(DIME));
    exp_q.push_back(2'(DIME));
    step(0, 0, 0, 0, 1);
    check("ch0_deposit", 32'(bus.deposit_o), 20);
    check("ch0_state", 32'(bus.dbg_state), 32'(CHANGE));
    check("ch0_vend", 32'(bus.vend_o), 0);
    step(0, 0, 0, 0, 0);
    check("ch1_deposit", 32'(bus.deposit_o), 10);
    step(0, 0, 0, 0, 0);
    check("ch2_deposit", 32'(bus.deposit_o), 0);
    check("ch2_state", 32'(bus.dbg_state), 32'(IDLE));
    check("ch2_busy", 32'(bus.busy_o), 0);
    idle_cycles($urandom_range(1, 3));

    // withheld acknowledge
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check("hold_vend", 32'(bus.vend_o), 1);
      check("hold_deposit", 32'(bus.deposit_o), 20);
      step(0, 0, 0, 0, 0);
    end
    step(0, 0, 0, 0, 1);
    check("hold_ack_vend", 32'(bus.vend_o), 0);
    check("hold_ack_deposit", 32'(bus.deposit_o), 0);
    idle_cycles($urandom_range(1, 3));

    // cancel with 15 cents deposited
    step(1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    check("cx_deposit", 32'(bus.deposit_o), 15);
`ifdef VEND_ACCEPT_REFUND_EN
    exp_q.push_back(2'(DIME));
    exp_q.push_back(2'(NICKEL));
    step(0, 0, 0, 1, 0);
    check("cx_state", 32'(bus.dbg_state), 32'(CHANGE));
    check("cx_vend", 32'(bus.vend_o), 0);
    step(0, 0, 0, 0, 0);
    check("cx1_deposit", 32'(bus.deposit_o), 5);
    check("cx1_vend", 32'(bus.vend_o), 0);
    step(0, 0, 0, 0, 0);
    check("cx2_deposit", 32'(bus.deposit_o), 0);
    check("cx2_state", 32'(bus.dbg_state), 32'(IDLE));
    check("cx2_vend", 32'(bus.vend_o), 0);
`else
    step(0, 0, 0, 1, 0);
    check("cx_ignored_deposit", 32'(bus.deposit_o), 15);
    check("cx_ignored_state", 32'(bus.dbg_state), 32'(COLLECT));
    check("cx_ignored_busy", 32'(bus.busy_o), 0);
    step(1, 0, 0, 0, 0);
    check("cx_fill_vend", 32'(bus.vend_o), 1);
    step(0, 0, 0, 0, 1);
    check("cx_fill_deposit", 32'(bus.deposit_o), 0);
`endif
    idle_cycles($urandom_range(1, 3));

    // reset while change of 10 is still owed
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    check("r30_deposit", 32'(bus.deposit_o), 30);
    step(0, 0, 0, 0, 1);
    check("r_ch_deposit", 32'(bus.deposit_o), 10);
    check("r_ch_state", 32'(bus.dbg_state), 32'(CHANGE));
    rst_n = 1'b0;
    #1;
    check("r_async_deposit", 32'(bus.deposit_o), 0);
    check("r_async_busy", 32'(bus.busy_o), 0);
    check("r_async_vend", 32'(bus.vend_o), 0);
    check("r_async_cvalid", 32'(bus.change_valid_o), 0);
    check("r_async_ccoin", 32'(bus.change_coin_o), 0);
    check("r_async_reject", 32'(bus.coin_reject_o), 0);
    check("r_async_state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    idle_cycles(5);
    check("r_after_deposit", 32'(bus.deposit_o), 0);

    check("reject_count", 32'(obs_reject), 32'(exp_reject));
    check("exp_q_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/vend_accept.md
VEND_ACCEPT -- requirements
Module: vend_accept

Interface
REQ-001 SHALL have parameter PRICE, default 20, item price in cents; legal values are multiples of 5 in 5..200.
REQ-002 SHALL derive localparam DEP_W = $clog2(PRICE+21), the deposit width; the maximum deposit is PRICE+20.
REQ-003 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 nickel_i / dime_i / quarter_i  in  1 each  coin-inserted strobes, one cycle per coin.
REQ-006 cancel_i  in  1  customer cancel request.
REQ-007 vend_ack_i  in  1  dispenser has taken the item.
REQ-008 vend_o  out  1  item release request.
REQ-009 change_valid_o  out  1  one-cycle pulse per returned coin.
REQ-010 change_coin_o  out  2  returned coin (0 none, 1 nickel, 2 dime, 3 quarter); it is 0 when change_valid_o is low.
REQ-011 coin_reject_o  out  1  one-cycle pulse when an inserted coin is refused.
REQ-012 busy_o  out  1  high in VEND or CHANGE.
REQ-013 deposit_o  out  DEP_W  current credit in cents.

Function
REQ-014 SHALL implement FSM states IDLE, COLLECT, VEND and CHANGE.
REQ-015 All outputs SHALL be registered.
REQ-016 In IDLE or COLLECT, the accepted coin SHALL be chosen with priority nickel > dime > quarter and added to deposit_o at that edge.
- Any other coin strobed in the same cycle SHALL pulse coin_reject_o on the next cycle.
REQ-017 Coin transitions from IDLE or COLLECT:
- After a coin add, deposit < PRICE -> COLLECT.
- After a coin add, deposit >= PRICE -> VEND.
- vend_o SHALL be high in the first cycle after that edge.
REQ-018 VEND SHALL hold vend_o high until vend_ack_i is sampled high. Then:
- deposit_o <= deposit_o - PRICE;
- vend_o SHALL drop;
- the next state SHALL be IDLE if the remainder is 0, else CHANGE.
REQ-019 vend_ack_i SHALL be ignored outside VEND.
REQ-020 CHANGE SHALL emit one coin per cycle: quarter if remainder >= 25, else dime if >= 10, else nickel.
- On each emitted coin, deposit_o SHALL decrease by that coin's value and change_valid_o SHALL pulse.
- When the remainder reaches 0, the next state SHALL be IDLE.
REQ-021 Every coin strobed during VEND or CHANGE SHALL be rejected (coin_reject_o pulse) and SHALL NOT change deposit_o.
REQ-022 Cancel behaviour:
- cancel_i in COLLECT SHALL move to CHANGE and return the full deposit.
- cancel_i in IDLE, VEND or CHANGE SHALL have no effect.
- cancel_i together with a coin in COLLECT: cancel wins and the coin is rejected.
REQ-023 deposit_o arithmetic SHALL be unsigned DEP_W-bit and SHALL never wrap; REQ-017 guarantees the bound.

Reset
REQ-024 rst_ni low SHALL immediately force:
- state to IDLE;
- deposit_o, vend_o, change_valid_o, change_coin_o, coin_reject_o and busy_o to 0.
REQ-025 Reset mid-VEND or mid-CHANGE SHALL discard the remaining credit; no further change is emitted.

Configuration
REQ-026 With macro VEND_ACCEPT_REFUND_EN defined, cancel_i SHALL behave per REQ-022.
REQ-027 Without VEND_ACCEPT_REFUND_EN, cancel_i SHALL remain a port but be ignored, and CHANGE SHALL be entered only from VEND.

Structure
REQ-028 Package vend_pkg SHALL hold:
- the FSM state enum;
- the coin enum (NONE, NICKEL, DIME, QUARTER);
- coin value constants 5/10/25.
REQ-029 Sub-module vend_change_sel (combinational) SHALL map a remainder to the next change coin and its value.

Verification
REQ-030 PRICE=20 -> dime, dime: vend_o high one cycle after the 2nd dime; ack -> IDLE; no change pulses.
REQ-031 Deposit 15 -> quarter (deposit 40) -> ack: two change pulses, each dime; deposit_o 20->10->0; then IDLE.
REQ-032 Nickel and dime in the same cycle: deposit_o=5 and one coin_reject_o pulse.
- A quarter during VEND: rejected, deposit_o unchanged.
REQ-033 VEND_ACCEPT_REFUND_EN defined, deposit 15, cancel_i: change dime then nickel, deposit 0, vend_o never high.
- Macro undefined: the same cancel is ignored and deposit stays 15.
REQ-034 vend_ack_i withheld 5 cycles: vend_o high all 5 cycles and deposit stays 20; ack -> vend_o low next cycle.
REQ-035 rst_ni low during CHANGE (remainder 10): all outputs 0 immediately; no pulses after release.
